// File: rtl/fpnew_mant_divsqrt_iter.sv
// -----------------------------------------------------------------------------
// fpnew_mant_divsqrt_iter
//
// Iterative radix-2 mantissa divider / square-root unit. Produces one result
// bit per cycle, MSB first, for QWIDTH = MANT_WIDTH+2 cycles (integer bit,
// MANT_WIDTH-1 fraction bits, guard, round), then reports the result for one
// cycle together with a sticky bit built from the final partial remainder.
// Exponent, sign and rounding are handled by the surrounding divsqrt wrapper.
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   div_start_i         start a division (wins if sqrt_start_i is also high)
//   sqrt_start_i        start a square root
//   mant_a_i            dividend / radicand, normalized (MSB=1), value [1,2)
//   mant_b_i            divisor, normalized; ignored for square root
//   exp_odd_i           square root only: radicand is 2*mant_a_i
//   kill_i              abort whatever is in flight, block a start
//   ready_o             a start is accepted this cycle (IDLE or DONE)
//   done_o              one-cycle pulse, result_o/sticky_o are fresh
//   result_o            quotient/root, MSB weight 2^0
//   sticky_o            exact result has bits below the round bit
//   busy_o              operation in flight (ITER or DONE)
// -----------------------------------------------------------------------------
module fpnew_mant_divsqrt_iter #(
  parameter  int unsigned MANT_WIDTH = 53,
  localparam int unsigned QWIDTH     = MANT_WIDTH + 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  div_start_i,
  input  logic                  sqrt_start_i,
  input  logic [MANT_WIDTH-1:0] mant_a_i,
  input  logic [MANT_WIDTH-1:0] mant_b_i,
  input  logic                  exp_odd_i,
  input  logic                  kill_i,
  output logic                  ready_o,
  output logic                  done_o,
  output logic [QWIDTH-1:0]     result_o,
  output logic                  sticky_o,
  output logic                  busy_o
);

  localparam int unsigned CNT_W = $clog2(QWIDTH);
  // Remainder width: the sqrt remainder needs QWIDTH+2 bits on the last
  // step (rem <= 2*root, shifted by two); the divider only needs
  // MANT_WIDTH+1 bits and shares the same register zero-extended.
  localparam int unsigned REM_W = QWIDTH + 2;
  // Radicand scaled so that its integer square root is directly the result:
  // rad = mant_a * 2^(MANT_WIDTH+3), or one more shift when exp_odd_i is set.
  localparam int unsigned RAD_W = 2 * QWIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ITER = 2'b01,
    DONE = 2'b10
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    is_sqrt_q, is_sqrt_d;
  logic [MANT_WIDTH-1:0]   divisor_q, divisor_d;
  logic [REM_W-1:0]        rem_q, rem_d;
  logic [QWIDTH-1:0]       quo_q, quo_d;
  logic [RAD_W-1:0]        rad_q, rad_d;
  logic [QWIDTH-1:0]       result_q, result_d;
  logic                    sticky_q, sticky_d;

  logic                    start_ok;
  logic [REM_W-1:0]        div_ext;
  logic                    div_ge;
  logic [REM_W-1:0]        div_rem;
  logic [REM_W-1:0]        sq_rem_sh;
  logic [REM_W-1:0]        sq_trial;
  logic                    sq_ge;
  logic [REM_W-1:0]        sq_rem;
  logic                    q_bit;
  logic [REM_W-1:0]        step_rem;
  logic [QWIDTH-1:0]       quo_next;

  // Decoded from state only, so ready_o never depends on the inputs.
  assign ready_o  = (state_q == IDLE) || (state_q == DONE);
  assign done_o   = (state_q == DONE);
  assign busy_o   = (state_q == ITER) || (state_q == DONE);
  assign result_o = result_q;
  assign sticky_o = sticky_q;

  assign start_ok = ready_o && (div_start_i || sqrt_start_i) && !kill_i;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_sqrt_d = is_sqrt_q;
    divisor_d = divisor_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    rad_d     = rad_q;
    result_d  = result_q;
    sticky_d  = sticky_q;

    // Restoring division step: compare, conditionally subtract.
    div_ext = {{(REM_W-MANT_WIDTH){1'b0}}, divisor_q};
    div_ge  = (rem_q >= div_ext);
    div_rem = div_ge ? (rem_q - div_ext) : rem_q;

    // Digit-by-digit square root step: bring down two radicand bits and
    // try to subtract 4*root+1.
    sq_rem_sh = {rem_q[REM_W-3:0], rad_q[RAD_W-1 -: 2]};
    sq_trial  = {quo_q, 2'b01};
    sq_ge     = (sq_rem_sh >= sq_trial);
    sq_rem    = sq_ge ? (sq_rem_sh - sq_trial) : sq_rem_sh;

    q_bit    = is_sqrt_q ? sq_ge : div_ge;
    step_rem = is_sqrt_q ? sq_rem : div_rem;
    quo_next = {quo_q[QWIDTH-2:0], q_bit};

    if (state_q == ITER) begin
      if (kill_i) begin
        state_d = IDLE;
      end else begin
        quo_d = quo_next;
        rem_d = is_sqrt_q ? sq_rem : {div_rem[REM_W-2:0], 1'b0};
        rad_d = {rad_q[RAD_W-3:0], 2'b00};
        if (cnt_q == '0) begin
          state_d  = DONE;
          result_d = quo_next;
          sticky_d = |step_rem;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
    end else if (start_ok) begin
      // IDLE or DONE (DONE covers the back-to-back case).
      state_d   = ITER;
      cnt_d     = CNT_W'(QWIDTH - 1);
      is_sqrt_d = sqrt_start_i && !div_start_i;
      divisor_d = mant_b_i;
      quo_d     = '0;
      if (sqrt_start_i && !div_start_i) begin
        rem_d = '0;
      end else begin
        rem_d = {{(REM_W-MANT_WIDTH){1'b0}}, mant_a_i};
      end
      if (exp_odd_i) begin
        rad_d = {mant_a_i, {(MANT_WIDTH+4){1'b0}}};
      end else begin
        rad_d = {1'b0, mant_a_i, {(MANT_WIDTH+3){1'b0}}};
      end
    end else begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      result_q <= '0;
      sticky_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      sticky_q <= sticky_d;
    end
    // Datapath registers carry no reset; they are loaded on every start.
    is_sqrt_q <= is_sqrt_d;
    divisor_q <= divisor_d;
    rem_q     <= rem_d;
    quo_q     <= quo_d;
    rad_q     <= rad_d;
  end

endmodule
